// File: rtl/ras_stack.sv
// Circular return address stack for the fetch predictor.
// Exposes the top index and depth so fetch can checkpoint them and the backend can restore on mispredict.
module ras_stack #(
  parameter int RAS_ENTRIES     = 16,
  parameter int LOG_RAS_ENTRIES = 4,
  parameter int PC_WIDTH        = 38
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       link_valid,
  input  logic [PC_WIDTH-1:0]        link_ret_addr,
  input  logic                       ret_valid,
  output logic [PC_WIDTH-1:0]        ret_target,
  output logic                       ret_hit,
  output logic [LOG_RAS_ENTRIES-1:0] ras_index,
  output logic [LOG_RAS_ENTRIES:0]   ras_count,
  input  logic                       restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0] restore_ras_index,
  input  logic [LOG_RAS_ENTRIES:0]   restore_ras_count
);

  localparam logic [LOG_RAS_ENTRIES:0] COUNT_FULL = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);
  localparam logic [LOG_RAS_ENTRIES:0] COUNT_ONE  = (LOG_RAS_ENTRIES+1)'(1);

  logic [PC_WIDTH-1:0]        entries [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0] top;
  logic [LOG_RAS_ENTRIES:0]   count;
  logic [LOG_RAS_ENTRIES-1:0] top_inc;
  logic [LOG_RAS_ENTRIES-1:0] top_dec;

  // Index arithmetic wraps naturally at the index width.
  assign top_inc = top + 1'b1;
  assign top_dec = top - 1'b1;

  assign ret_target = entries[top];
  assign ret_hit    = (count != '0);
  assign ras_index  = top;
  assign ras_count  = count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      top   <= '0;
      count <= '0;
    end else if (restore_valid) begin
      top   <= restore_ras_index;
      count <= restore_ras_count;
    end else if (link_valid && ret_valid) begin
      // Coroutine swap: replace the top entry in place.
      entries[top] <= link_ret_addr;
      if (count == '0) begin
        count <= COUNT_ONE;
      end
    end else if (link_valid) begin
      // When full this lands on the oldest entry, which is intentionally lost.
      entries[top_inc] <= link_ret_addr;
      top              <= top_inc;
      if (count != COUNT_FULL) begin
        count <= count + COUNT_ONE;
      end
    end else if (ret_valid && (count != '0)) begin
      top   <= top_dec;
      count <= count - COUNT_ONE;
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// Directed self-checking bench for ras_stack: push/pop, overflow wrap, swap, restore priority,
// underflow and reset-with-push.
module tb_ras_stack;

  localparam int RAS_ENTRIES     = 16;
  localparam int LOG_RAS_ENTRIES = 4;
  localparam int PC_WIDTH        = 38;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic                       link_valid;
  logic [PC_WIDTH-1:0]        link_ret_addr;
  logic                       ret_valid;
  logic [PC_WIDTH-1:0]        ret_target;
  logic                       ret_hit;
  logic [LOG_RAS_ENTRIES-1:0] ras_index;
  logic [LOG_RAS_ENTRIES:0]   ras_count;
  logic                       restore_valid;
  logic [LOG_RAS_ENTRIES-1:0] restore_ras_index;
  logic [LOG_RAS_ENTRIES:0]   restore_ras_count;

  int errors = 0;
  int checks = 0;

  ras_stack #(
    .RAS_ENTRIES(RAS_ENTRIES),
    .LOG_RAS_ENTRIES(LOG_RAS_ENTRIES),
    .PC_WIDTH(PC_WIDTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .link_valid(link_valid),
    .link_ret_addr(link_ret_addr),
    .ret_valid(ret_valid),
    .ret_target(ret_target),
    .ret_hit(ret_hit),
    .ras_index(ras_index),
    .ras_count(ras_count),
    .restore_valid(restore_valid),
    .restore_ras_index(restore_ras_index),
    .restore_ras_count(restore_ras_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    RST               = 1'b0;
    link_valid        = 1'b0;
    link_ret_addr     = '0;
    ret_valid         = 1'b0;
    restore_valid     = 1'b0;
    restore_ras_index = '0;
    restore_ras_count = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
  endtask

  task automatic push(input logic [PC_WIDTH-1:0] addr);
    link_valid    = 1'b1;
    link_ret_addr = addr;
    tick();
  endtask

  task automatic pop();
    ret_valid = 1'b1;
    tick();
  endtask

  task automatic restore(input int idx, input int cnt);
    restore_valid     = 1'b1;
    restore_ras_index = LOG_RAS_ENTRIES'(idx);
    restore_ras_count = (LOG_RAS_ENTRIES+1)'(cnt);
    tick();
  endtask

  task automatic check_state(input string tag, input int idx, input int cnt);
    check({tag, ".index"}, 64'(ras_index), 64'(idx));
    check({tag, ".count"}, 64'(ras_count), 64'(cnt));
    check({tag, ".hit"},   64'(ret_hit),   64'(cnt != 0));
  endtask

  initial begin
    idle_inputs();
    @(negedge CLK);
    do_reset();
    tick();

    // reset then idle
    check_state("reset", 0, 0);
    check("reset.target", 64'(ret_target), 64'h0);

    // two pushes, two pops
    push(38'h100);
    push(38'h200);
    check_state("push2", 2, 2);
    check("push2.target", 64'(ret_target), 64'h200);
    ret_valid = 1'b1;
    #1;
    check("pop1.target", 64'(ret_target), 64'h200);
    tick();
    ret_valid = 1'b1;
    #1;
    check("pop2.target", 64'(ret_target), 64'h100);
    tick();
    check_state("pop_end", 0, 0);

    // overflow: 17 pushes into 16 entries
    do_reset();
    for (int i = 1; i <= 17; i++) push(PC_WIDTH'(i));
    check_state("ovf", 1, 16);
    check("ovf.target", 64'(ret_target), 64'h11);
    for (int i = 17; i >= 2; i--) begin
      check($sformatf("ovf_pop%0d.target", i), 64'(ret_target), 64'(i));
      pop();
    end
    check_state("ovf_drained", 1, 0);

    // coroutine swap
    do_reset();
    push(38'hA0);
    link_valid    = 1'b1;
    ret_valid     = 1'b1;
    link_ret_addr = 38'hB0;
    #1;
    check("swap.cycle_target", 64'(ret_target), 64'hA0);
    check_state("swap.cycle", 1, 1);
    tick();
    check("swap.after_target", 64'(ret_target), 64'hB0);
    check_state("swap.after", 1, 1);

    // swap on empty stack raises count to 1
    do_reset();
    link_valid    = 1'b1;
    ret_valid     = 1'b1;
    link_ret_addr = 38'hC0;
    tick();
    check_state("swap_empty", 0, 1);
    check("swap_empty.target", 64'(ret_target), 64'hC0);

    // restore beats a push in the same cycle
    do_reset();
    push(38'h111);
    push(38'h222);
    push(38'h333);
    check_state("pre_restore", 3, 3);
    link_valid    = 1'b1;
    link_ret_addr = 38'h444;
    restore_valid     = 1'b1;
    restore_ras_index = 4'd1;
    restore_ras_count = 5'd1;
    tick();
    check_state("restore", 1, 1);
    check("restore.target", 64'(ret_target), 64'h111);
    restore(4, 4);
    check("restore.push_dropped", 64'(ret_target), 64'h0);
    restore(2, 16);
    check_state("restore_full", 2, 16);
    check("restore_full.target", 64'(ret_target), 64'h222);

    // underflow leaves state unchanged
    do_reset();
    pop();
    check_state("underflow", 0, 0);
    check("underflow.target", 64'(ret_target), 64'h0);

    // reset wins over a push in the same cycle, and clears the array
    push(38'h555);
    check("pre_rst.target", 64'(ret_target), 64'h555);
    RST           = 1'b1;
    link_valid    = 1'b1;
    link_ret_addr = 38'h666;
    tick();
    check_state("rst_push", 0, 0);
    restore(1, 1);
    check("rst_push.entry1", 64'(ret_target), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return address stack for the fetch predictor. It is fed by the BTB action decode (JUMP_L / RET / RET_L) and its output is consumed by next-PC selection.
- Circular stack of PC38 return addresses with an exposed top index and count. Fetch checkpoints these with each prediction; the backend restores them on a mispredict.
- Overflow silently overwrites the oldest entry.

Parameters:
- RAS_ENTRIES, 16, number of stack entries (power of 2).
- LOG_RAS_ENTRIES, 4, clog2(RAS_ENTRIES); width of the index.
- PC_WIDTH, 38, width of a stored return address (PC38).

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- link_valid  input  1  push request (JUMP_L, INDIRECT_L, RET_L).
- link_ret_addr  input  PC_WIDTH  return address to push.
- ret_valid  input  1  pop request (RET, RET_L).
- ret_target  output  PC_WIDTH  entry at current top index (combinational read of array[top]).
- ret_hit  output  1  count != 0; the ret_target value is meaningful.
- ras_index  output  LOG_RAS_ENTRIES  current top index, checkpointed by fetch.
- ras_count  output  LOG_RAS_ENTRIES+1  current valid depth, checkpointed by fetch.
- restore_valid  input  1  mispredict repair.
- restore_ras_index  input  LOG_RAS_ENTRIES  index to restore.
- restore_ras_count  input  LOG_RAS_ENTRIES+1  count to restore; always <= RAS_ENTRIES.

Behaviour:
- State:
  - entry array, RAS_ENTRIES x PC_WIDTH flops;
  - top (LOG_RAS_ENTRIES bits), points at the most recent entry;
  - count (LOG_RAS_ENTRIES+1 bits).
- Reset (RST high at posedge): all entries = 0, top = 0, count = 0. Resulting outputs: ret_target = 0, ret_hit = 0, ras_index = 0, ras_count = 0.
- RST has priority over every request, including any in flight in the same cycle.
- Read path: ret_target = array[top] and ret_hit = (count != 0), both combinational with zero latency. ras_index and ras_count are registered state.
- Each cycle, the first matching case below applies:
  1. restore_valid = 1: top <= restore_ras_index, count <= restore_ras_count. The array is untouched. link_valid and ret_valid in the same cycle are ignored.
  2. link_valid & ret_valid (RET_L coroutine swap): array[top] <= link_ret_addr. top is unchanged. count <= max(count,1). ret_target this cycle still shows the old array[top].
  3. link_valid only (push): top <= top+1 mod RAS_ENTRIES, array[top+1] <= link_ret_addr, count <= min(count+1, RAS_ENTRIES). When full, the push overwrites the oldest entry.
  4. ret_valid only, count != 0 (pop): top <= top-1 mod RAS_ENTRIES, count <= count-1.
  5. ret_valid only, count == 0 (underflow): no state change. ret_hit = 0 tells next-PC select to fall back to the BTB target.
  6. Otherwise: hold.
- Index arithmetic wraps modulo RAS_ENTRIES with no extra wrap bit. count saturates at RAS_ENTRIES and never goes below 0.
- Restore does not repair overwritten entries. A stale entry after a deep mispredict is an accepted misprediction, not an error.
- No backpressure: every request completes in one cycle and there is no stall output.

Test Plan:
- Reset then idle. Expect ret_target = 0, ret_hit = 0, ras_index = 0, ras_count = 0.
- Push 0x100, then 0x200, then pop twice. Expect:
  - after the pushes: ras_index = 2, ras_count = 2, ret_target = 0x200;
  - first pop cycle shows 0x200; second pop cycle shows 0x100;
  - end state: ras_index = 0, ras_count = 0, ret_hit = 0.
- Overflow: push 17 addresses 0x1..0x11. Expect:
  - ras_count = 16, ras_index = 1 (wrapped), ret_target = 0x11;
  - 16 pops return 0x11 down to 0x2, then ret_hit = 0.
- Swap: push 0xA0, then assert link_valid and ret_valid together with 0xB0. Expect:
  - ret_target shows 0xA0 in the swap cycle and 0xB0 on the next cycle;
  - ras_index = 1 and ras_count = 1 throughout.
- Restore priority: with depth 3 (index 3), assert restore_valid (index 1, count 1) together with link_valid. Expect ras_index = 1, ras_count = 1, the push dropped, and ret_target = the first pushed address.
- Underflow and reset mid-operation:
  - pop on empty leaves the state unchanged with ret_hit = 0;
  - RST asserted together with a push leaves index 0, count 0, and array[1] = 0.
